// File: rtl/line_scan_ctrl.sv
// Line sequencer: walks the endpoint bounding box row-major, one candidate per cycle,
// and streams pixels whose edge determinant satisfies 2*|det| <= max(|dx|,|dy|).
module line_scan_ctrl #(
  parameter int CW = 16,
  parameter int DW = 2*CW+2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [CW-1:0] i_x0,
  input  logic [CW-1:0] i_y0,
  input  logic [CW-1:0] i_x1,
  input  logic [CW-1:0] i_y1,
  output logic          o_pix_valid,
  input  logic          i_pix_ready,
  output logic [CW-1:0] o_pix_x,
  output logic [CW-1:0] o_pix_y,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int         EXT     = DW-CW-1;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 r_cmd_ready;
  logic [CW-1:0]        r_x0, r_y0;
  logic [CW-1:0]        r_xmin, r_xmax, r_ymin, r_ymax;
  logic signed [CW:0]   r_dx, r_dy;
  logic [CW:0]          r_thr;
  logic [CW-1:0]        r_cx, r_cy;
  logic                 r_pix_valid;
  logic [CW-1:0]        r_pix_x, r_pix_y;

  logic                 w_accept;
  logic signed [CW:0]   w_dx_in, w_dy_in;
  logic [CW:0]          w_adx, w_ady;
  logic [CW-1:0]        w_xmin, w_xmax, w_ymin, w_ymax;
  logic signed [CW:0]   w_rx, w_ry;
  logic signed [DW-1:0] w_dx_ext, w_dy_ext, w_rx_ext, w_ry_ext;
  logic signed [DW-1:0] w_p1, w_p2, w_det;
  logic [DW-1:0]        w_adet;
  logic                 w_cov;
  logic                 w_slot_free;
  logic                 w_last;

  // Command-side arithmetic, only meaningful on the accepting cycle.
  assign w_accept = i_cmd_valid && r_cmd_ready;
  assign w_dx_in  = $signed({1'b0, i_x1}) - $signed({1'b0, i_x0});
  assign w_dy_in  = $signed({1'b0, i_y1}) - $signed({1'b0, i_y0});
  assign w_adx    = w_dx_in[CW] ? -w_dx_in : w_dx_in;
  assign w_ady    = w_dy_in[CW] ? -w_dy_in : w_dy_in;
  assign w_xmin   = (i_x0 < i_x1) ? i_x0 : i_x1;
  assign w_xmax   = (i_x0 < i_x1) ? i_x1 : i_x0;
  assign w_ymin   = (i_y0 < i_y1) ? i_y0 : i_y1;
  assign w_ymax   = (i_y0 < i_y1) ? i_y1 : i_y0;

  // Each product is bounded by 2^(2CW), so their difference fits DW bits exactly.
  assign w_rx     = $signed({1'b0, r_cx}) - $signed({1'b0, r_x0});
  assign w_ry     = $signed({1'b0, r_cy}) - $signed({1'b0, r_y0});
  assign w_dx_ext = {{EXT{r_dx[CW]}}, r_dx};
  assign w_dy_ext = {{EXT{r_dy[CW]}}, r_dy};
  assign w_rx_ext = {{EXT{w_rx[CW]}}, w_rx};
  assign w_ry_ext = {{EXT{w_ry[CW]}}, w_ry};
  assign w_p1     = w_dx_ext * w_ry_ext;
  assign w_p2     = w_dy_ext * w_rx_ext;
  assign w_det    = w_p1 - w_p2;
  assign w_adet   = w_det[DW-1] ? -w_det : w_det;
  assign w_cov    = {w_adet, 1'b0} <= {{(DW-CW){1'b0}}, r_thr};

  assign w_slot_free = !r_pix_valid || i_pix_ready;
  assign w_last      = (r_cx == r_xmax) && (r_cy == r_ymax);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_slot_free && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_slot_free) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_xmin      <= '0;
      r_xmax      <= '0;
      r_ymin      <= '0;
      r_ymax      <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_thr       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x0   <= i_x0;
            r_y0   <= i_y0;
            r_xmin <= w_xmin;
            r_xmax <= w_xmax;
            r_ymin <= w_ymin;
            r_ymax <= w_ymax;
            r_dx   <= w_dx_in;
            r_dy   <= w_dy_in;
            r_thr  <= (w_adx > w_ady) ? w_adx : w_ady;
            r_cx   <= w_xmin;
            r_cy   <= w_ymin;
          end
        end
        S_SCAN: begin
          if (w_slot_free) begin
            r_pix_valid <= w_cov;
            if (w_cov) begin
              r_pix_x <= r_cx;
              r_pix_y <= r_cy;
            end
            // Counters stop on the final corner so they never wrap at 2^CW-1.
            if (!w_last) begin
              if (r_cx != r_xmax) begin
                r_cx <= r_cx + CW'(1);
              end else begin
                r_cx <= r_xmin;
                r_cy <= r_cy + CW'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          if (r_pix_valid && i_pix_ready) r_pix_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_pix_valid = r_pix_valid;
  assign o_pix_x     = r_pix_x;
  assign o_pix_y     = r_pix_y;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_line_scan_ctrl.sv
// Scoreboard bench for line_scan_ctrl: expected pixels are queued at command handshake,
// a negedge monitor pops and compares on every accepted pixel and on each done pulse.
module tb_line_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [15:0] pix_x, pix_y;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pix    = 0;
  int n_done   = 0;
  int cur_cnt  = 0;
  int mode     = 0;
  int hold_cnt = 0;
  bit held     = 1'b0;

  logic [31:0] exp_q[$];
  int          cnt_q[$];

  bit          prev_stall = 1'b0;
  bit          prev_done  = 1'b0;
  logic [15:0] prev_x, prev_y;
  logic [31:0] e;

  int tab_x[8] = '{2, 3, 3, 4, 5, 6, 6, 7};
  int tab_y[8] = '{1, 2, 3, 4, 5, 6, 7, 8};

  line_scan_ctrl #(.CW(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_x0        (x0),
    .i_y0        (y0),
    .i_x1        (x1),
    .i_y1        (y1),
    .o_pix_valid (pix_valid),
    .i_pix_ready (pix_ready),
    .o_pix_x     (pix_x),
    .o_pix_y     (pix_y),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: every bbox point, row-major, kept when 2*|det| <= max(|dx|,|dy|).
  task automatic push_model(input int ax, input int ay, input int bx, input int by);
    int dx, dy, thr, cnt;
    longint det;
    dx  = bx - ax;
    dy  = by - ay;
    thr = ((dx < 0 ? -dx : dx) > (dy < 0 ? -dy : dy)) ? (dx < 0 ? -dx : dx) : (dy < 0 ? -dy : dy);
    cnt = 0;
    for (int y = (ay < by ? ay : by); y <= (ay < by ? by : ay); y++)
      for (int x = (ax < bx ? ax : bx); x <= (ax < bx ? bx : ax); x++) begin
        det = longint'(dx) * longint'(y - ay) - longint'(dy) * longint'(x - ax);
        if (2 * (det < 0 ? -det : det) <= longint'(thr)) begin
          exp_q.push_back({16'(x), 16'(y)});
          cnt++;
        end
      end
    cnt_q.push_back(cnt);
  endtask

  task automatic send(input int ax, input int ay, input int bx, input int by, input bit use_tab);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    x0 = 16'(ax); y0 = 16'(ay); x1 = 16'(bx); y1 = 16'(by);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now("cmd_handshake_timeout");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (use_tab) begin
        for (int i = 0; i < 8; i++) exp_q.push_back({16'(tab_x[i]), 16'(tab_y[i])});
        cnt_q.push_back(8);
      end else begin
        push_model(ax, ay, bx, by);
      end
      #1;
      cmd_valid = 1'b0;
      x0 = 16'($urandom); y0 = 16'($urandom); x1 = 16'($urandom); y1 = 16'($urandom);
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      if (n_done >= target) return;
    end
    fail_now("done_timeout");
  endtask

  // Downstream ready pattern: 0 always, 1 toggle, 2 toggle plus 10-cycle stall on (4,4), 3 random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: pix_ready = ~pix_ready;
        2: begin
          if (hold_cnt > 0) begin
            hold_cnt--;
            pix_ready = 1'b0;
          end else if (!held && pix_valid && pix_x == 16'd4 && pix_y == 16'd4) begin
            held = 1'b1;
            hold_cnt = 9;
            pix_ready = 1'b0;
          end else begin
            pix_ready = ~pix_ready;
          end
        end
        3: pix_ready = ($urandom_range(0, 99) < 70);
        default: pix_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      cur_cnt    = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", pix_valid, 1'b1);
        chk("stall_xy_stable", {pix_x, pix_y}, {prev_x, prev_y});
      end
      if (prev_done) begin
        chk("done_single_cycle", done, 1'b0);
        chk("busy_low_after_done", busy, 1'b0);
        chk("cmd_ready_after_done", cmd_ready, 1'b1);
      end
      if (busy) chk("cmd_ready_low_while_busy", cmd_ready, 1'b0);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_pixel");
        end else begin
          e = exp_q.pop_front();
          chk("pixel_xy", {pix_x, pix_y}, e);
        end
        cur_cnt++;
        n_pix++;
      end
      if (done) begin
        if (cnt_q.size() == 0) fail_now("unexpected_done");
        else chk("pixels_per_line", cur_cnt, cnt_q.pop_front());
        cur_cnt = 0;
        n_done++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_x     = pix_x;
      prev_y     = pix_y;
      prev_done  = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_expired at %0t", $time);
    $fatal(1, "simulation watchdog");
  end

  initial begin
    int d0, ax, ay, bx, by;
    bit ok;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_pix_xy", {pix_x, pix_y}, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("cmd_ready_after_release", cmd_ready, 1'b1);

    // Diagonal line with free-flowing output, plus first-pixel latency.
    mode = 0;
    d0 = n_done;
    send(2, 1, 7, 8, 1'b1);
    @(negedge clk);
    chk("lat_busy", busy, 1'b1);
    chk("lat_no_pixel_yet", pix_valid, 1'b0);
    @(negedge clk);
    chk("lat_first_pixel_valid", pix_valid, 1'b1);
    chk("lat_first_pixel_xy", {pix_x, pix_y}, {16'd2, 16'd1});
    wait_done(d0 + 1, 200);

    d0 = n_done;
    send(7, 8, 2, 1, 1'b1);
    wait_done(d0 + 1, 200);

    d0 = n_done;
    send(0, 0, 4, 0, 1'b0);
    wait_done(d0 + 1, 100);
    d0 = n_done;
    send(3, 3, 3, 3, 1'b0);
    wait_done(d0 + 1, 100);

    // Backpressure with toggling ready and a long stall.
    mode = 2;
    held = 1'b0;
    d0 = n_done;
    send(2, 1, 7, 8, 1'b1);
    wait_done(d0 + 1, 400);
    mode = 0;

    // A second command held while the first line is busy.
    d0 = n_done;
    send(2, 1, 7, 8, 1'b1);
    repeat (5) @(posedge clk);
    send(0, 0, 9, 9, 1'b0);
    wait_done(d0 + 2, 400);

    // Random lines, some hugging the top of the coordinate range.
    for (int i = 0; i < 16; i++) begin
      mode = ($urandom_range(0, 1) == 0) ? 0 : 3;
      ax = $urandom_range(0, 12); ay = $urandom_range(0, 12);
      bx = $urandom_range(0, 12); by = $urandom_range(0, 12);
      if (i % 4 == 3) begin
        ax = 65535 - ax; bx = 65535 - bx;
        ay = 65535 - ay; by = 65535 - by;
      end
      d0 = n_done;
      send(ax, ay, bx, by, 1'b0);
      wait_done(d0 + 1, 2000);
    end
    mode = 0;
    repeat (3) @(posedge clk);
    chk("all_pixels_consumed", exp_q.size(), 0);
    chk("all_lines_completed", cnt_q.size(), 0);

    // Reset in the middle of a line.
    d0 = n_pix;
    send(2, 1, 7, 8, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (n_pix - d0 >= 3) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("midline_pixel_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pix_valid", pix_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_cmd_ready", cmd_ready, 1'b0);
    exp_q.delete();
    cnt_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cmd_ready_after_release", cmd_ready, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_stray_pixel", pix_valid, 1'b0);
    chk("midrst_idle_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
